aes_mixcolumns_engine: RTL
==========================

Name: aes_mixcolumns_engine

Overview:
Sequential, parametrised AES MixColumns / InvMixColumns unit operating on a full 128-bit state. Accepts a state over a valid/ready handshake and processes LANES columns per cycle. Holds the result until downstream accepts it. It sits between the ShiftRows and AddRoundKey stages of the round datapath. Selectable per transaction between the forward and inverse transform, so the encrypt and decrypt rounds share one instance.

Parameters:
LANES, 1, columns processed per cycle; legal values 1, 2, 4; any other value is a synthesis error.
INV_EN, 1, 1 = inverse transform hardware present; 0 = forward only, and the inverse input is ignored.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  state_in/inverse valid
in_ready  output  1  engine can accept a state this cycle
inverse  input  1  1 = InvMixColumns, 0 = MixColumns; sampled on accept
state_in  input  128  input state
out_valid  output  1  state_out valid
out_ready  input  1  downstream accepts state_out
state_out  output  128  transformed state
busy  output  1  high in CALC or DONE

Behaviour:
- Clock and reset: one clock, clk; reset is reset_n, asynchronous assert, active-low, deasserted synchronously upstream. Reset values: in_ready=1, out_valid=0, busy=0, state_out=0. The FSM goes to IDLE, the column counter to 0 and the stored mode to 0.
- Layout: column c (0..3) occupies bits [127-32c : 96-32c]. Within a column, row 0 is the MSB byte [31:24].
- Forward matrix rows: 02 03 01 01 / 01 02 03 01 / 01 01 02 03 / 03 01 01 02.
- Inverse matrix rows: 0e 0b 0d 09 / 09 0e 0b 0d / 0d 09 0e 0b / 0b 0d 09 0e.
- GF(2^8) arithmetic: xtime(b) = {b[6:0],0} ^ (0x1b if b[7]). Higher multiples are built from chained xtime and XOR only; no lookup tables.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch state_in into the working register, latch the mode (forced to 0 when INV_EN=0), clear the counter and go to CALC.
  - CALC: each cycle transform columns counter..counter+LANES-1 in place, then increment the counter by LANES. On the cycle that completes column 3, go to DONE.
  - DONE: out_valid=1 and state_out equals the working register.
    - On out_ready=1 with in_valid=0: go to IDLE.
    - On out_ready=1 with in_valid=1: the new state is accepted in the same cycle (in_ready = out_ready in DONE) and the FSM goes directly to CALC. No bubble.
- Latency: accept at edge T gives out_valid high after edge T+4/LANES, i.e. 4, 2 or 1 CALC cycles.
- Throughput with out_ready held high:
  - LANES=4: one result every 2 cycles.
  - LANES=1: one result every 5 cycles.
- Stability: state_out and out_valid are stable while out_valid=1 and out_ready=0.
- Ignored inputs:
  - inputs are ignored in CALC, and in DONE while out_ready=0;
  - out_ready is ignored when out_valid=0.
- Inverse path: the inverse input changing mid-transaction has no effect, because the mode is latched on accept.
- Reset mid-operation: the transaction is discarded immediately and no out_valid is produced for it.
- Counter: 2 bits; wraps to 0 on entering DONE.

Test Plan:
- FIPS-197 App. B round 1, forward, LANES=4: state_in = d4bf5d30_e0b452ae_b84111f1_1e2798e5 -> state_out = 046681e5_e0cb199a_48f8d37a_2806264c, with out_valid exactly 1 cycle after accept.
- Same vector with inverse=1, state_in = 046681e5_e0cb199a_48f8d37a_2806264c -> state_out = d4bf5d30_e0b452ae_b84111f1_1e2798e5. Repeat for LANES=1 and 2, checking latency of 4 and 2 cycles.
- Column vectors, forward:
  - state_in = db135345_f20a225c_01010101_2d26314c -> state_out = 8e4da1bc_9fdc589d_01010101_4d7ebdf8.
  - state_in = c6c6c6c6_d4d4d4d5_00000000_ffffffff -> state_out = c6c6c6c6_d5d5d7d6_00000000_ffffffff.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Require state_out stable, in_ready=0, and in_valid pulses ignored. Then raise out_ready with in_valid=1: the new state is accepted in the same cycle and the next out_valid follows after 4/LANES cycles.
- Back-to-back stream of 8 random states with out_ready=1, compared against a reference model. Includes mixed inverse modes, and inverse toggled mid-CALC (no effect). With INV_EN=0, inverse=1 still yields the forward result.
- Assert reset_n low during CALC: outputs return to reset values asynchronously. After release, in_ready=1, no spurious out_valid, and the next transaction is correct.

Source files
------------

// File: rtl/aes_mixcolumns_engine.sv
// AES MixColumns / InvMixColumns engine.
// A full 128-bit state is accepted over valid/ready. LANES columns are
// transformed in place each CALC cycle. The result is held in DONE until
// downstream takes it, and a new state may be accepted in that same cycle.
module aes_mixcolumns_engine #(
  parameter int LANES  = 1,
  parameter int INV_EN = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inverse,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  // Only 1, 2 or 4 lanes divide the four columns evenly.
  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("aes_mixcolumns_engine: LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  // Index 0 is the most significant word, so cols_t[c] is column c.
  typedef logic [0:3][31:0] cols_t;

  localparam logic [1:0] LP_STEP   = 2'(LANES);      // 4 lanes wraps to 0
  localparam logic [1:0] LP_LAST   = 2'(4 - LANES);  // first column of the final group
  localparam logic       LP_INV_EN = (INV_EN != 0);

  state_e     r_fsm;
  logic [1:0] r_cnt;
  logic       r_inv;
  cols_t      r_work;

  cols_t      w_calc;
  logic [1:0] w_idx;
  logic       w_last;
  logic       w_accept;

  // Multiply by 02 in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Transform one column; the higher multiples are chained xtime and XOR.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    int          r1, r2, r3;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int r = 0; r < 4; r++) begin
      r1 = (r + 1) % 4;
      r2 = (r + 2) % 4;
      r3 = (r + 3) % 4;
      if (inv) begin
        // 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3]
        res[31-8*r -: 8] = (x8[r]  ^ x4[r]  ^ x2[r])
                         ^ (x8[r1] ^ x2[r1] ^ a[r1])
                         ^ (x8[r2] ^ x4[r2] ^ a[r2])
                         ^ (x8[r3] ^ a[r3]);
      end else begin
        // 02*a[r] ^ 03*a[r+1] ^ a[r+2] ^ a[r+3]
        res[31-8*r -: 8] = x2[r] ^ (x2[r1] ^ a[r1]) ^ a[r2] ^ a[r3];
      end
    end
    return res;
  endfunction

  // Handshake and status decodes from the state register.
  assign in_ready  = (r_fsm == S_IDLE) || ((r_fsm == S_DONE) && out_ready);
  assign out_valid = (r_fsm == S_DONE);
  assign busy      = (r_fsm != S_IDLE);
  assign state_out = r_work;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == LP_LAST);

  // Working state with the current lane group transformed in place.
  always_comb begin
    // NOTE: defaults come first so every path assigns, which keeps this block free of latches.
    w_calc = r_work;
    w_idx  = r_cnt;
    for (int l = 0; l < LANES; l++) begin
      w_idx         = r_cnt + 2'(l);
      w_calc[w_idx] = mix_col(r_work[w_idx], LP_INV_EN & r_inv);
    end
  end

  // Control FSM, column counter, latched mode and working register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm  <= S_IDLE;
      r_cnt  <= '0;
      r_inv  <= 1'b0;
      // NOTE: the working register is reset too, because it drives state_out directly.
      r_work <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      case (r_fsm)
        S_IDLE: begin
          if (w_accept) begin
            r_work <= state_in;
            r_inv  <= inverse & LP_INV_EN;
            r_cnt  <= '0;
            r_fsm  <= S_CALC;
          end
        end
        S_CALC: begin
          r_work <= w_calc;
          if (w_last) begin
            r_cnt <= '0;
            r_fsm <= S_DONE;
          end else begin
            r_cnt <= r_cnt + LP_STEP;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              r_work <= state_in;
              r_inv  <= inverse & LP_INV_EN;
              r_cnt  <= '0;
              r_fsm  <= S_CALC;
            end else begin
              r_fsm <= S_IDLE;
            end
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

endmodule
